// File: rtl/efeito_fim_jogo.sv
// End-of-game effect generator: defeat blink and victory LED chase on the 1 Hz game clock.
// Outputs are a pure combinational decode of the state and counter registers.
module efeito_fim_jogo #(
    parameter int NUM_HEX         = 8,
    parameter int NUM_LEDR        = 18,
    parameter int MEIO_PERIODO    = 1,
    parameter int NUM_PISCADAS    = 0,
    parameter int NUM_VOLTAS      = 0,
    parameter int SEG_ATIVO_BAIXO = 1
) (
    input  logic                   clk_1Hz,
    input  logic                   reset,
    input  logic                   sinalderrota,
    input  logic                   sinalvitoria,
    output logic [7*NUM_HEX-1:0]   HEX,
    output logic [NUM_LEDR-1:0]    LEDR,
    output logic                   ativo,
    output logic                   fim
);

    localparam int FASE_W  = $clog2(MEIO_PERIODO) + 1;
    localparam int PISC_W  = $clog2(NUM_PISCADAS + 1) + 1;
    localparam int POS_W   = $clog2(NUM_LEDR) + 1;
    localparam int VOLTA_W = $clog2(NUM_VOLTAS + 1) + 1;

    localparam logic [FASE_W-1:0]  FASE_MAX    = FASE_W'(MEIO_PERIODO - 1);
    localparam logic [FASE_W-1:0]  FASE_UM     = FASE_W'(1);
    localparam logic [PISC_W-1:0]  PISC_ALVO   = PISC_W'(NUM_PISCADAS);
    localparam logic [PISC_W-1:0]  PISC_UM     = PISC_W'(1);
    localparam logic [POS_W-1:0]   POS_MAX     = POS_W'(NUM_LEDR - 1);
    localparam logic [POS_W-1:0]   POS_UM      = POS_W'(1);
    localparam logic [VOLTA_W-1:0] VOLTA_ALVO  = VOLTA_W'(NUM_VOLTAS);
    localparam logic [VOLTA_W-1:0] VOLTA_UM    = VOLTA_W'(1);
    localparam bit                 PISC_LIMITE = (NUM_PISCADAS != 0);
    localparam bit                 VOLTA_LIMITE = (NUM_VOLTAS != 0);

    localparam logic [6:0] SEG_ACESO   = (SEG_ATIVO_BAIXO != 0) ? 7'h00 : 7'h7F;
    localparam logic [6:0] SEG_APAGADO = ~SEG_ACESO;

    typedef enum logic [2:0] {
        IDLE,
        D_ON,
        D_OFF,
        V_CHASE,
        HOLD_D,
        HOLD_V
    } estado_t;

    estado_t              r_estado, w_estado_prox;
    logic [FASE_W-1:0]    r_fase, w_fase_prox;
    logic [PISC_W-1:0]    r_piscadas, w_piscadas_prox;
    logic [POS_W-1:0]     r_pos, w_pos_prox;
    logic [VOLTA_W-1:0]   r_voltas, w_voltas_prox;
    logic [VOLTA_W-1:0]   w_voltas_inc;

    assign w_voltas_inc = r_voltas + VOLTA_UM;

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            r_estado   <= IDLE;
            r_fase     <= '0;
            r_piscadas <= '0;
            r_pos      <= '0;
            r_voltas   <= '0;
        end else begin
            r_estado   <= w_estado_prox;
            r_fase     <= w_fase_prox;
            r_piscadas <= w_piscadas_prox;
            r_pos      <= w_pos_prox;
            r_voltas   <= w_voltas_prox;
        end
    end

    always_comb begin
        w_estado_prox   = r_estado;
        w_fase_prox     = r_fase;
        w_piscadas_prox = r_piscadas;
        w_pos_prox      = r_pos;
        w_voltas_prox   = r_voltas;
        case (r_estado)
            IDLE: begin
                // Defeat is checked first so it wins when both triggers rise together
                if (sinalderrota) begin
                    w_estado_prox   = D_ON;
                    w_fase_prox     = '0;
                    w_piscadas_prox = '0;
                end else if (sinalvitoria) begin
                    w_estado_prox = V_CHASE;
                    w_fase_prox   = '0;
                    w_pos_prox    = '0;
                    w_voltas_prox = '0;
                end
            end
            D_ON: begin
                if (!sinalderrota) begin
                    w_estado_prox = IDLE;
                    w_fase_prox   = '0;
                end else if (r_fase == FASE_MAX) begin
                    w_estado_prox   = D_OFF;
                    w_fase_prox     = '0;
                    w_piscadas_prox = r_piscadas + PISC_UM;
                end else begin
                    w_fase_prox = r_fase + FASE_UM;
                end
            end
            D_OFF: begin
                if (!sinalderrota) begin
                    w_estado_prox = IDLE;
                    w_fase_prox   = '0;
                end else if (r_fase == FASE_MAX) begin
                    w_fase_prox = '0;
                    if (PISC_LIMITE && (r_piscadas == PISC_ALVO)) begin
                        w_estado_prox = HOLD_D;
                    end else begin
                        w_estado_prox = D_ON;
                    end
                end else begin
                    w_fase_prox = r_fase + FASE_UM;
                end
            end
            HOLD_D: begin
                if (!sinalderrota) begin
                    w_estado_prox = IDLE;
                end
            end
            V_CHASE: begin
                if (sinalderrota) begin
                    w_estado_prox   = D_ON;
                    w_fase_prox     = '0;
                    w_piscadas_prox = '0;
                    w_pos_prox      = '0;
                    w_voltas_prox   = '0;
                end else if (!sinalvitoria) begin
                    w_estado_prox = IDLE;
                    w_fase_prox   = '0;
                    w_pos_prox    = '0;
                end else if (r_fase == FASE_MAX) begin
                    w_fase_prox = '0;
                    if (r_pos == POS_MAX) begin
                        w_pos_prox    = '0;
                        w_voltas_prox = w_voltas_inc;
                        if (VOLTA_LIMITE && (w_voltas_inc == VOLTA_ALVO)) begin
                            w_estado_prox = HOLD_V;
                        end
                    end else begin
                        w_pos_prox = r_pos + POS_UM;
                    end
                end else begin
                    w_fase_prox = r_fase + FASE_UM;
                end
            end
            HOLD_V: begin
                if (sinalderrota) begin
                    w_estado_prox   = D_ON;
                    w_fase_prox     = '0;
                    w_piscadas_prox = '0;
                    w_pos_prox      = '0;
                    w_voltas_prox   = '0;
                end else if (!sinalvitoria) begin
                    w_estado_prox = IDLE;
                    w_pos_prox    = '0;
                end
            end
            default: begin
                w_estado_prox   = IDLE;
                w_fase_prox     = '0;
                w_piscadas_prox = '0;
                w_pos_prox      = '0;
                w_voltas_prox   = '0;
            end
        endcase
    end

    always_comb begin
        HEX   = {NUM_HEX{SEG_APAGADO}};
        LEDR  = '0;
        ativo = (r_estado != IDLE);
        fim   = (r_estado == HOLD_D) || (r_estado == HOLD_V);
        case (r_estado)
            D_ON, HOLD_D: begin
                HEX  = {NUM_HEX{SEG_ACESO}};
                LEDR = '1;
            end
            V_CHASE: begin
                // The walking digit repeats every NUM_HEX LED positions
                for (int i = 0; i < NUM_HEX; i++) begin
                    if ((int'(r_pos) % NUM_HEX) == i) begin
                        HEX[7*i +: 7] = SEG_ACESO;
                    end
                end
                for (int i = 0; i < NUM_LEDR; i++) begin
                    LEDR[i] = (int'(r_pos) == i);
                end
            end
            HOLD_V: begin
                LEDR = '1;
            end
            default: begin
                HEX  = {NUM_HEX{SEG_APAGADO}};
                LEDR = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_efeito_fim_jogo.sv
// Scoreboard bench for efeito_fim_jogo: two parameterisations driven by directed vectors.
module tb_efeito_fim_jogo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA = 1'b1, derA = 1'b0, vitA = 1'b0;
    logic        rstB = 1'b1, derB = 1'b0, vitB = 1'b0;
    logic [55:0] hexA, hexB;
    logic [17:0] ledA, ledB;
    logic        atA, atB, fimA, fimB;

    efeito_fim_jogo #(.NUM_VOLTAS(1)) dutA (
        .clk_1Hz(clk), .reset(rstA), .sinalderrota(derA), .sinalvitoria(vitA),
        .HEX(hexA), .LEDR(ledA), .ativo(atA), .fim(fimA)
    );

    efeito_fim_jogo #(.MEIO_PERIODO(2), .NUM_PISCADAS(2)) dutB (
        .clk_1Hz(clk), .reset(rstB), .sinalderrota(derB), .sinalvitoria(vitB),
        .HEX(hexB), .LEDR(ledB), .ativo(atB), .fim(fimB)
    );

    typedef struct {
        int          dut;
        logic [55:0] hex;
        logic [17:0] ledr;
        logic        ativo;
        logic        fim;
        string       nome;
    } exp_t;

    exp_t fila[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [55:0] HEX_LIT  = 56'h0;
    localparam logic [55:0] HEX_DARK = {56{1'b1}};
    localparam logic [17:0] LED_ALL  = 18'h3FFFF;

    function automatic exp_t mk(input logic [55:0] h, input logic [17:0] l,
                                input logic a, input logic f);
        exp_t e;
        e.dut = 0; e.hex = h; e.ledr = l; e.ativo = a; e.fim = f; e.nome = "";
        return e;
    endfunction

    function automatic exp_t e_blank();
        return mk(HEX_DARK, 18'h0, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_lit(input logic f);
        return mk(HEX_LIT, LED_ALL, 1'b1, f);
    endfunction
    function automatic exp_t e_dark();
        return mk(HEX_DARK, 18'h0, 1'b1, 1'b0);
    endfunction
    function automatic exp_t e_holdv();
        return mk(HEX_DARK, LED_ALL, 1'b1, 1'b1);
    endfunction
    function automatic exp_t e_chase(input int p);
        logic [55:0] h;
        logic [17:0] l;
        h = HEX_DARK;
        h[7*(p%8) +: 7] = 7'h00;
        l = 18'h1;
        l = l << p;
        return mk(h, l, 1'b1, 1'b0);
    endfunction

    // Drive inputs just after a falling edge; the expectation is for the next rising edge
    task automatic step(input int d, input logic rs, input logic dr, input logic vi,
                        input exp_t e, input string nm);
        @(negedge clk);
        #1;
        if (d == 0) begin
            rstA = rs; derA = dr; vitA = vi;
        end else begin
            rstB = rs; derB = dr; vitB = vi;
        end
        e.dut  = d;
        e.nome = nm;
        fila.push_back(e);
    endtask

    // Monitor: one expectation consumed per falling edge
    initial begin
        exp_t        e;
        logic [55:0] h;
        logic [17:0] l;
        logic        a, f;
        forever begin
            @(negedge clk);
            if (fila.size() > 0) begin
                e = fila.pop_front();
                if (e.dut == 0) begin
                    h = hexA; l = ledA; a = atA; f = fimA;
                end else begin
                    h = hexB; l = ledB; a = atB; f = fimB;
                end
                n_cmp++;
                if (h !== e.hex || l !== e.ledr || a !== e.ativo || f !== e.fim) begin
                    n_err++;
                    $display("FAIL %s: got HEX=%h LEDR=%h ativo=%b fim=%b, need HEX=%h LEDR=%h ativo=%b fim=%b",
                             e.nome, h, l, a, f, e.hex, e.ledr, e.ativo, e.fim);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state of both instances, then release
        step(0, 1'b1, 1'b0, 1'b0, e_blank(), "rstA");
        step(1, 1'b1, 1'b0, 1'b0, e_blank(), "rstB");
        step(0, 1'b0, 1'b0, 1'b0, e_blank(), "idleA");
        step(1, 1'b0, 1'b0, 1'b0, e_blank(), "idleB");

        // Defeat toggles every edge with default timing
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(0, 1'b0, 1'b1, 1'b0, e_lit(1'b0), "t1_on");
            else            step(0, 1'b0, 1'b1, 1'b0, e_dark(),   "t1_off");
        end
        step(0, 1'b0, 1'b0, 1'b0, e_blank(), "t1_exit");

        // Victory chase, one full loop then hold
        for (int p = 0; p < 18; p++) begin
            step(0, 1'b0, 1'b0, 1'b1, e_chase(p), "t3_chase");
        end
        step(0, 1'b0, 1'b0, 1'b1, e_holdv(), "t3_hold");
        step(0, 1'b0, 1'b0, 1'b1, e_holdv(), "t3_hold2");
        step(0, 1'b0, 1'b0, 1'b0, e_blank(), "t3_exit");

        // Both triggers together: defeat wins
        step(0, 1'b0, 1'b1, 1'b1, e_lit(1'b0), "t4_on");
        step(0, 1'b0, 1'b1, 1'b1, e_dark(),    "t4_off");
        step(0, 1'b0, 1'b1, 1'b1, e_lit(1'b0), "t4_on2");
        step(0, 1'b0, 1'b0, 1'b0, e_blank(),   "t4_exit");

        // Pre-emption of the chase at pos 5
        for (int p = 0; p < 6; p++) begin
            step(0, 1'b0, 1'b0, 1'b1, e_chase(p), "t5_chase");
        end
        step(0, 1'b0, 1'b1, 1'b1, e_lit(1'b0), "t5_preempt");
        step(0, 1'b0, 1'b0, 1'b1, e_blank(),   "t5_exit");
        step(0, 1'b0, 1'b0, 1'b1, e_chase(0),  "t5_restart0");
        step(0, 1'b0, 1'b0, 1'b1, e_chase(1),  "t5_restart1");
        step(0, 1'b0, 1'b0, 1'b0, e_blank(),   "t5_stop");

        // Asynchronous reset in the middle of D_ON
        step(0, 1'b0, 1'b1, 1'b0, e_lit(1'b0), "t6_on");
        step(0, 1'b0, 1'b1, 1'b0, e_dark(),    "t6_off");
        @(negedge clk);
        @(posedge clk);
        #2;
        rstA = 1'b1;
        begin
            exp_t e;
            e = e_blank();
            e.dut = 0;
            e.nome = "t6_async";
            fila.push_back(e);
        end
        step(0, 1'b0, 1'b1, 1'b0, e_lit(1'b0), "t6_release");
        step(0, 1'b0, 1'b1, 1'b0, e_dark(),    "t6_off2");
        step(0, 1'b0, 1'b0, 1'b0, e_blank(),   "t6_exit");

        // Slow blink with a finite count, then steady hold
        for (int i = 0; i < 8; i++) begin
            if ((i / 2) % 2 == 0) step(1, 1'b0, 1'b1, 1'b0, e_lit(1'b0), "t2_on");
            else                  step(1, 1'b0, 1'b1, 1'b0, e_dark(),   "t2_off");
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1'b0, 1'b1, 1'b0, e_lit(1'b1), "t2_hold");
        end
        step(1, 1'b0, 1'b0, 1'b0, e_blank(), "t2_exit");

        @(negedge clk);
        @(negedge clk);
        #1;
        if (fila.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, need 0", fila.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
